// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Brief    : Round-robin arbiter sharing one SDRAM burst port between the
//            instruction cache (read-only) and the data cache (fill/writeback).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int ADDR_WIDTH     = 13,
  parameter int DATA_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  // instruction cache refill port
  input  logic                  i_mem_req,
  input  logic [ADDR_WIDTH-1:0] i_mem_address,
  output logic                  i_mem_ready,
  output logic [DATA_WIDTH-1:0] i_from_mem,
  // data cache refill / writeback port
  input  logic                  d_mem_req,
  input  logic                  d_mem_wren,
  input  logic [ADDR_WIDTH-1:0] d_mem_address,
  input  logic [DATA_WIDTH-1:0] d_to_mem,
  output logic                  d_mem_ready,
  output logic [DATA_WIDTH-1:0] d_from_mem,
  // SDRAM controller burst port
  output logic                  sdram_req,
  output logic                  sdram_wren,
  output logic [ADDR_WIDTH-1:0] sdram_address,
  output logic [DATA_WIDTH-1:0] sdram_wdata,
  input  logic [DATA_WIDTH-1:0] sdram_rdata,
  input  logic                  sdram_ready,
  // debug / status
  output logic                  grant_i,
  output logic                  grant_d,
  output logic                  timeout_err
);

  localparam int c_WD_WIDTH = $clog2(TIMEOUT_CYCLES);
  localparam logic [c_WD_WIDTH-1:0] c_WD_MAX = c_WD_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic                    r_last_grant_d;
  logic                    r_wren;
  logic [ADDR_WIDTH-1:0]   r_address;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [c_WD_WIDTH-1:0]   r_watchdog;
  logic [c_WD_WIDTH-1:0]   w_watchdog_inc;
  logic                    r_timeout;
  logic                    w_grant_edge;
  logic                    w_busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // A tie goes to whichever side did not win last; last grant resets to I.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_mem_req && d_mem_req) begin
          w_next_state = r_last_grant_d ? ST_BUSY_I : ST_BUSY_D;
        end else if (i_mem_req) begin
          w_next_state = ST_BUSY_I;
        end else if (d_mem_req) begin
          w_next_state = ST_BUSY_D;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        if (sdram_ready) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign w_grant_edge   = (r_state == ST_IDLE) && (w_next_state != ST_IDLE);
  assign w_busy         = (r_state == ST_BUSY_I) || (r_state == ST_BUSY_D);
  assign w_watchdog_inc = r_watchdog + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_grant_d <= 1'b0;
      r_wren         <= 1'b0;
      r_address      <= '0;
      r_wdata        <= '0;
    end else if (w_grant_edge) begin
      r_last_grant_d <= (w_next_state == ST_BUSY_D);
      if (w_next_state == ST_BUSY_D) begin
        r_wren    <= d_mem_wren;
        r_address <= d_mem_address;
        r_wdata   <= d_to_mem;
      end else begin
        r_wren    <= 1'b0;
        r_address <= i_mem_address;
      end
    end
  end

  // Watchdog only flags a stalled controller; the transaction keeps running.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_watchdog <= '0;
      r_timeout  <= 1'b0;
    end else if (w_grant_edge) begin
      r_watchdog <= '0;
    end else if (w_busy && !sdram_ready && (r_watchdog != c_WD_MAX)) begin
      r_watchdog <= w_watchdog_inc;
      if (w_watchdog_inc == c_WD_MAX) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign sdram_req     = w_busy && !sdram_ready;
  assign sdram_wren    = r_wren;
  assign sdram_address = r_address;
  assign sdram_wdata   = r_wdata;

  assign grant_i       = (r_state == ST_BUSY_I);
  assign grant_d       = (r_state == ST_BUSY_D);
  assign i_mem_ready   = grant_i && sdram_ready;
  assign d_mem_ready   = grant_d && sdram_ready;
  assign i_from_mem    = sdram_rdata;
  assign d_from_mem    = sdram_rdata;
  assign timeout_err   = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Directed, table-driven self-checking bench for mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  localparam int AW = 13;
  localparam int DW = 64;
  localparam logic [DW-1:0] RDATA = 64'hDEAD_BEEF_CAFE_0001;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_mem_req = 1'b0;
  logic [AW-1:0] i_mem_address = '0;
  logic          i_mem_ready;
  logic [DW-1:0] i_from_mem;
  logic          d_mem_req = 1'b0;
  logic          d_mem_wren = 1'b0;
  logic [AW-1:0] d_mem_address = '0;
  logic [DW-1:0] d_to_mem = '0;
  logic          d_mem_ready;
  logic [DW-1:0] d_from_mem;
  logic          sdram_req;
  logic          sdram_wren;
  logic [AW-1:0] sdram_address;
  logic [DW-1:0] sdram_wdata;
  logic [DW-1:0] sdram_rdata = RDATA;
  logic          sdram_ready = 1'b0;
  logic          grant_i;
  logic          grant_d;
  logic          timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_mem_req     (i_mem_req),
    .i_mem_address (i_mem_address),
    .i_mem_ready   (i_mem_ready),
    .i_from_mem    (i_from_mem),
    .d_mem_req     (d_mem_req),
    .d_mem_wren    (d_mem_wren),
    .d_mem_address (d_mem_address),
    .d_to_mem      (d_to_mem),
    .d_mem_ready   (d_mem_ready),
    .d_from_mem    (d_from_mem),
    .sdram_req     (sdram_req),
    .sdram_wren    (sdram_wren),
    .sdram_address (sdram_address),
    .sdram_wdata   (sdram_wdata),
    .sdram_rdata   (sdram_rdata),
    .sdram_ready   (sdram_ready),
    .grant_i       (grant_i),
    .grant_d       (grant_d),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, required finish before 100us");
    $fatal(1);
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b, expected %0b", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          i_req;
    logic          d_req;
    logic          d_wren;
    logic          rdy;
    logic [AW-1:0] d_addr;
    logic          e_req;
    logic          e_wren;
    logic [AW-1:0] e_addr;
    logic          e_ir;
    logic          e_dr;
    logic          e_gi;
    logic          e_gd;
    logic          e_to;
  } vec_t;

  vec_t vecs[10];

  initial begin
    // D fill: request, five stalled BUSY cycles, completion, then a stray ready in IDLE.
    vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 13'h0ABC, 1'b0, 1'b0, 13'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int k = 1; k <= 5; k++)
      vecs[k] = '{1'b0, 1'b1, 1'b0, 1'b0, 13'h0ABC, 1'b1, 1'b0, 13'h0ABC, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 13'h0ABC, 1'b0, 1'b0, 13'h0ABC, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 13'h0ABC, 1'b0, 1'b0, 13'h0ABC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 13'h0ABC, 1'b0, 1'b0, 13'h0ABC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 13'h0ABC, 1'b0, 1'b0, 13'h0ABC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset state
    @(negedge clk);
    chk1("rst_sdram_req", sdram_req, 1'b0);
    chk1("rst_sdram_wren", sdram_wren, 1'b0);
    chkw("rst_sdram_address", 64'(sdram_address), 64'h0);
    chkw("rst_sdram_wdata", sdram_wdata, 64'h0);
    chk1("rst_grant_i", grant_i, 1'b0);
    chk1("rst_grant_d", grant_d, 1'b0);
    chk1("rst_timeout", timeout_err, 1'b0);
    chk1("rst_i_ready", i_mem_ready, 1'b0);
    chk1("rst_d_ready", d_mem_ready, 1'b0);
    step();
    rst = 1'b1;

    // Table-driven vectors
    for (int v = 0; v < 10; v++) begin
      step();
      i_mem_req     = vecs[v].i_req;
      d_mem_req     = vecs[v].d_req;
      d_mem_wren    = vecs[v].d_wren;
      d_mem_address = vecs[v].d_addr;
      sdram_ready   = vecs[v].rdy;
      @(negedge clk);
      chk1($sformatf("v%0d_sdram_req", v), sdram_req, vecs[v].e_req);
      chk1($sformatf("v%0d_sdram_wren", v), sdram_wren, vecs[v].e_wren);
      chkw($sformatf("v%0d_sdram_address", v), 64'(sdram_address), 64'(vecs[v].e_addr));
      chk1($sformatf("v%0d_i_ready", v), i_mem_ready, vecs[v].e_ir);
      chk1($sformatf("v%0d_d_ready", v), d_mem_ready, vecs[v].e_dr);
      chk1($sformatf("v%0d_grant_i", v), grant_i, vecs[v].e_gi);
      chk1($sformatf("v%0d_grant_d", v), grant_d, vecs[v].e_gd);
      chk1($sformatf("v%0d_timeout", v), timeout_err, vecs[v].e_to);
      if (vecs[v].e_dr) chkw($sformatf("v%0d_d_from_mem", v), d_from_mem, RDATA);
    end
    sdram_ready = 1'b0;

    // Round-robin from reset: both sides always requesting -> D, I, D, I
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    i_mem_address = 13'h0123;
    d_mem_address = 13'h0456;
    d_mem_wren    = 1'b0;
    i_mem_req     = 1'b1;
    d_mem_req     = 1'b1;
    @(negedge clk);
    chk1("rr_idle_req", sdram_req, 1'b0);
    for (int t = 0; t < 4; t++) begin
      automatic logic exp_d = (t % 2 == 0);
      step();
      @(negedge clk);
      chk1($sformatf("rr%0d_req", t), sdram_req, 1'b1);
      chk1($sformatf("rr%0d_grant_d", t), grant_d, exp_d);
      chk1($sformatf("rr%0d_grant_i", t), grant_i, !exp_d);
      chkw($sformatf("rr%0d_addr", t), 64'(sdram_address), exp_d ? 64'h456 : 64'h123);
      step();
      sdram_ready = 1'b1;
      @(negedge clk);
      chk1($sformatf("rr%0d_d_ready", t), d_mem_ready, exp_d);
      chk1($sformatf("rr%0d_i_ready", t), i_mem_ready, !exp_d);
      step();
      sdram_ready = 1'b0;
      @(negedge clk);
      chk1($sformatf("rr%0d_gap_req", t), sdram_req, 1'b0);
      chk1($sformatf("rr%0d_gap_grant", t), grant_i | grant_d, 1'b0);
    end
    i_mem_req = 1'b0;
    d_mem_req = 1'b0;

    // Writeback; requester inputs change while BUSY and must be ignored
    step();
    d_mem_req     = 1'b1;
    d_mem_wren    = 1'b1;
    d_mem_address = 13'h1FFF;
    d_to_mem      = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    chk1("wb_idle_req", sdram_req, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      step();
      if (k == 1) begin
        d_mem_address = 13'h0001;
        d_to_mem      = 64'h0;
        d_mem_wren    = 1'b0;
      end
      @(negedge clk);
      chk1($sformatf("wb%0d_req", k), sdram_req, 1'b1);
      chk1($sformatf("wb%0d_wren", k), sdram_wren, 1'b1);
      chkw($sformatf("wb%0d_wdata", k), sdram_wdata, 64'h0123_4567_89AB_CDEF);
      chkw($sformatf("wb%0d_addr", k), 64'(sdram_address), 64'h1FFF);
    end
    step();
    sdram_ready = 1'b1;
    @(negedge clk);
    chk1("wb_d_ready", d_mem_ready, 1'b1);
    chk1("wb_i_ready", i_mem_ready, 1'b0);
    chk1("wb_ready_req", sdram_req, 1'b0);
    step();
    sdram_ready = 1'b0;
    d_mem_req   = 1'b0;
    @(negedge clk);
    chk1("wb_after_req", sdram_req, 1'b0);

    // Watchdog (TIMEOUT_CYCLES=8); I drops its request mid-transaction
    step();
    i_mem_req     = 1'b1;
    i_mem_address = 13'h0AAA;
    @(negedge clk);
    chk1("wd_idle_req", sdram_req, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      step();
      i_mem_req = 1'b0;
      @(negedge clk);
      chk1($sformatf("wd%0d_req", k), sdram_req, 1'b1);
      chk1($sformatf("wd%0d_grant_i", k), grant_i, 1'b1);
      chk1($sformatf("wd%0d_timeout", k), timeout_err, (k >= 8));
    end
    step();
    sdram_ready = 1'b1;
    @(negedge clk);
    chk1("wd_i_ready", i_mem_ready, 1'b1);
    chk1("wd_d_ready", d_mem_ready, 1'b0);
    step();
    sdram_ready = 1'b0;
    @(negedge clk);
    chk1("wd_after_req", sdram_req, 1'b0);
    chk1("wd_sticky", timeout_err, 1'b1);

    // Asynchronous reset mid BUSY_D
    step();
    d_mem_req  = 1'b1;
    d_mem_wren = 1'b0;
    step();
    @(negedge clk);
    chk1("ar_busy_req", sdram_req, 1'b1);
    chk1("ar_busy_grant_d", grant_d, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk1("ar_req_dropped", sdram_req, 1'b0);
    chk1("ar_grant_d_dropped", grant_d, 1'b0);
    chk1("ar_timeout_cleared", timeout_err, 1'b0);
    step();
    rst       = 1'b1;
    i_mem_req = 1'b1;
    d_mem_req = 1'b1;
    @(negedge clk);
    chk1("ar_idle_req", sdram_req, 1'b0);
    step();
    @(negedge clk);
    chk1("ar_tie_grant_d", grant_d, 1'b1);
    chk1("ar_tie_grant_i", grant_i, 1'b0);
    i_mem_req = 1'b0;
    d_mem_req = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
